// File: rtl/io_pipe_pkg.sv
// Shared types for the I/O pipe mux: the output view selector.
package io_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_DELAY  = 2'd1,
    MODE_EDGE   = 2'd2,
    MODE_STICKY = 2'd3
  } mode_e;

endpackage

// File: rtl/io_pipe_mux_if.sv
// Pin-side bus of the I/O pipe mux: control/sample inputs and the selected view outputs.
// Protocol: no valid/ready handshake; every input is sampled on each rising clk edge where
// en=1, and outputs are stable registered views that only change on such edges (or reset).
interface io_pipe_mux_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic             clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_oe;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output en, mode, clr, din,
    input  dout, dout_oe, edge_cnt
  );

  modport slave (
    input  en, mode, clr, din,
    output dout, dout_oe, edge_cnt
  );
endinterface

// File: rtl/io_delay_line.sv
// DEPTH-stage shift register with enable hold and synchronous active-high reset.
module io_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/io_pipe_mux.sv
// Registered pin passthrough with selectable views (pass, delay, rising-edge, sticky)
// and a saturating count of cycles that contain at least one rising edge.
module io_pipe_mux
  import io_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  io_pipe_mux_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s1_prev;
  logic [WIDTH-1:0] sticky;
  logic [WIDTH-1:0] delayed;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] view;
  logic [CNT_W-1:0] cnt;
  mode_e            mode_q;

  // Fed from s1 so DELAY latency is DEPTH+1 from din, and it runs in every mode
  // so switching into DELAY shows real history.
  io_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .d   (s1),
    .q   (delayed)
  );

  assign rise = s1 & ~s1_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s1_prev <= '0;
      sticky  <= '0;
      oe_q    <= '0;
      cnt     <= '0;
      mode_q  <= MODE_PASS;
    end else if (bus.en) begin
      s1      <= bus.din;
      s1_prev <= s1;
      oe_q    <= '1;
      mode_q  <= mode_e'(bus.mode);
      // Clear wins over both the sticky set and the counter increment.
      if (bus.clr) begin
        sticky <= '0;
        cnt    <= '0;
      end else begin
        sticky <= sticky | s1;
        if ((|rise) && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    view = s1;
    case (mode_q)
      MODE_PASS:   view = s1;
      MODE_DELAY:  view = delayed;
      MODE_EDGE:   view = rise;
      MODE_STICKY: view = sticky;
      default:     view = s1;
    endcase
  end

  assign bus.dout     = view;
  assign bus.dout_oe  = oe_q;
  assign bus.edge_cnt = cnt;

endmodule
